pc_sequencer: RTL and testbench

//  Parametrised program-counter / next-PC sequencer for the MIPS core, replacing the inline PC logic.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_sequencer_irq_sync.sv | 35 +++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core front end: pc_src encodings, default vectors
// and instruction alignment.
package cpu_pkg;

  localparam logic [2:0] PCSRC_SEQ   = 3'b000;
  localparam logic [2:0] PCSRC_BR    = 3'b001;
  localparam logic [2:0] PCSRC_J     = 3'b010;
  localparam logic [2:0] PCSRC_JR    = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;

  localparam logic [31:0] START_VEC = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  localparam int INSTR_ALIGN = 2;

  // True when pc_src moves the PC somewhere other than pc+4.
  function automatic logic is_redirect(logic [2:0] src, logic cond);
    return !((src == PCSRC_SEQ) || ((src == PCSRC_BR) && !cond));
  endfunction

endpackage

// File: rtl/pc_sequencer_irq_sync.sv
// irq_sync: multi-flop synchroniser for the async irq level, rising-edge detect
// and a sticky pending flag that only an explicit clear drops.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic clr_i,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_prev_q;
  logic                   pend_q, pend_d;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~lvl_prev_q;
  // A new edge wins over a same-cycle clear so no request is dropped.
  assign pend_d    = rise | (pend_q & ~clr_i);
  assign pending_o = pend_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_i};
      lvl_prev_q <= sync_q[SYNC_STAGES-1];
      pend_q     <= pend_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter / next-PC select with irq and exception vectoring,
// EPC capture and an optional redirect trace buffer (enabled by PC_TRACE_EN).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] START       = START_VEC,
  parameter logic [31:0] ILLOP       = ILLOP_VEC,
  parameter logic [31:0] XADR        = XADR_VEC,
  parameter int          SYNC_STAGES = 2,
  parameter int          TRACE_DEPTH = 8,
  localparam int         IDX_W       = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [2:0]        pc_src,
  input  logic              cond,
  input  logic [31:0]       imm32,
  input  logic [25:0]       jt,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              illegal_op,
  input  logic              irq_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              kernel,
  output logic              irq_take,
  output logic              exc_take,
  output logic [ADDR_W-1:0] epc,
  input  logic [IDX_W-1:0]  trace_idx,
  output logic [ADDR_W-1:0] trace_pc
);

  localparam int LW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] START_A = START[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ILLOP_A = ILLOP[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] XADR_A  = XADR[ADDR_W-1:0];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] target, br_target;
  logic [LW-1:0]     br_off;
  logic              misaligned, pending, irq_clr;

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign kernel   = pc_q[ADDR_W-1];
  // Increments only touch the low bits; the kernel bit is never carried into.
  assign pc_plus4 = {pc_q[ADDR_W-1], pc_q[LW-1:0] + LW'(4)};
  assign br_off    = {imm32[ADDR_W-4:0], 2'b00};
  assign br_target = {pc_q[ADDR_W-1], pc_plus4[LW-1:0] + br_off};

  always_comb begin
    target = START_A;
    case (pc_src)
      PCSRC_SEQ:   target = pc_plus4;
      PCSRC_BR:    target = cond ? br_target : pc_plus4;
      PCSRC_J:     target = {pc_q[ADDR_W-1:28], jt, 2'b00};
      PCSRC_JR:    target = reg_target;
      PCSRC_ILLOP: target = ILLOP_A;
      PCSRC_XADR:  target = XADR_A;
      default:     target = START_A;
    endcase
  end

  assign misaligned = (pc_src == PCSRC_JR) && (reg_target[INSTR_ALIGN-1:0] != '0);
  assign exc_take   = illegal_op | misaligned;
  assign irq_take   = pending & ~kernel & ~exc_take;
  assign irq_clr    = advance & irq_take;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_i     (clk),
    .rst_i     (reset),
    .irq_i     (irq_in),
    .clr_i     (irq_clr),
    .pending_o (pending)
  );

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (advance) begin
      if (exc_take) begin
        pc_d  = XADR_A;
        epc_d = pc_q;
      end else if (irq_take) begin
        pc_d  = ILLOP_A;
        epc_d = pc_q;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= START_A;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

`ifdef PC_TRACE_EN
  logic [ADDR_W-1:0] trace_q [TRACE_DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr;
  logic              trace_wr;

  assign trace_wr = advance & (exc_take | irq_take | is_redirect(pc_src, cond));
  assign wr_ptr_d = trace_wr ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
  // wr_ptr points at the next free slot, so the newest entry sits one behind it.
  assign rd_ptr   = wr_ptr_q - IDX_W'(1) - trace_idx;
  assign trace_pc = trace_q[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (trace_wr) trace_q[wr_ptr_q] <= pc_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx;
  assign trace_pc     = '0;
`endif

  // Upper immediate bits fall off the top of the shifted branch offset.
  logic unused_imm;
  assign unused_imm = ^imm32;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against an arithmetic reference
// model; directed scenarios first, then a long random run with async resets.
module tb_pc_sequencer;

  localparam int          AW = 32;
  localparam int          S  = 2;
  localparam int          TD = 8;
  localparam logic [31:0] START_V = 32'h0000_0000;
  localparam logic [31:0] ILLOP_V = 32'h8000_0004;
  localparam logic [31:0] XADR_V  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        advance, cond, illegal_op, irq_in;
  logic [2:0]  pc_src;
  logic [31:0] imm32, reg_target;
  logic [25:0] jt;
  logic [2:0]  trace_idx;
  logic [31:0] pc, pc_plus4, epc, trace_pc;
  logic        kernel, irq_take, exc_take;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(AW), .START(START_V), .ILLOP(ILLOP_V), .XADR(XADR_V),
    .SYNC_STAGES(S), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .advance(advance), .pc_src(pc_src), .cond(cond),
    .imm32(imm32), .jt(jt), .reg_target(reg_target), .illegal_op(illegal_op),
    .irq_in(irq_in), .pc(pc), .pc_plus4(pc_plus4), .kernel(kernel),
    .irq_take(irq_take), .exc_take(exc_take), .epc(epc),
    .trace_idx(trace_idx), .trace_pc(trace_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc;
  logic        m_pend;
  logic [S+1:0] m_hist;       // m_hist[j] = irq_in sampled j edges ago
  logic [31:0] m_trace[$];    // newest first

  function automatic logic [31:0] seq_add(input logic [31:0] base, input logic [31:0] off);
    return (base & 32'h8000_0000) | ((base + off) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic m_exc();
    return illegal_op || (pc_src == 3'd3 && reg_target[1:0] != 2'b00);
  endfunction

  function automatic logic m_irq();
    return m_pend && !m_pc[31] && !m_exc();
  endfunction

  function automatic logic [31:0] m_target();
    case (pc_src)
      3'd0: return seq_add(m_pc, 32'd4);
      3'd1: return cond ? seq_add(m_pc, 32'd4 + (imm32 << 2)) : seq_add(m_pc, 32'd4);
      3'd2: return (m_pc & 32'hF000_0000) | (32'(jt) << 2);
      3'd3: return reg_target;
      3'd4: return ILLOP_V;
      3'd5: return XADR_V;
      default: return START_V;
    endcase
  endfunction

  function automatic logic [31:0] m_trace_exp(input logic [2:0] idx);
`ifdef PC_TRACE_EN
    if (int'(idx) < m_trace.size()) return m_trace[int'(idx)];
    return 32'h0;
`else
    return (idx == 3'd0) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic m_reset();
    m_pc = START_V; m_epc = 32'h0; m_pend = 1'b0; m_hist = '0;
    m_trace.delete();
  endtask

  task automatic m_step();
    logic e, i, rise, redir;
    logic [31:0] nxt;
    e = m_exc();
    i = m_irq();
    redir = !(pc_src == 3'd0 || (pc_src == 3'd1 && !cond));
    nxt = e ? XADR_V : (i ? ILLOP_V : m_target());
    m_hist = {m_hist[S:0], irq_in};
    rise = m_hist[S] && !m_hist[S+1];
    if (advance) begin
      if (e || i) m_epc = m_pc;
      if (e || i || redir) begin
        m_trace.push_front(nxt);
        if (m_trace.size() > TD) void'(m_trace.pop_back());
      end
      m_pc = nxt;
    end
    m_pend = rise || (m_pend && !(advance && i));
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    chk("pc_plus4", pc_plus4, seq_add(m_pc, 32'd4));
    chk("kernel", 32'(kernel), 32'(m_pc[31]));
    chk("irq_take", 32'(irq_take), 32'(m_irq()));
    chk("exc_take", 32'(exc_take), 32'(m_exc()));
    chk("trace_pc", trace_pc, m_trace_exp(trace_idx));
  endtask

  // Entered at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic cyc();
    #1 check_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 chk("rst_async_pc", pc, START_V);
    chk("rst_async_epc", epc, 32'h0);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic drive(input logic [2:0] src, input logic [31:0] rt, input logic [25:0] j);
    pc_src = src; reg_target = rt; jt = j;
  endtask

  logic [31:0] held;
  logic [31:0] exp_tr;

  initial begin
    reset = 1'b1; advance = 1'b1; pc_src = 3'd0; cond = 1'b0; imm32 = 32'h0;
    jt = '0; reg_target = 32'h0; illegal_op = 1'b0; irq_in = 1'b0; trace_idx = 3'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_pc_plus4", pc_plus4, 32'h4);
    chk("reset_trace", trace_pc, 32'h0);
    reset = 1'b0;

    // sequential fetch
    cyc(); chk("seq_pc1", pc, 32'h4);
    cyc(); chk("seq_pc2", pc, 32'h8);
    cyc(); chk("seq_pc3", pc, 32'hC);
    chk("seq_epc", epc, 32'h0);
    cyc(); chk("seq_pc4", pc, 32'h10);

    // branch taken backwards / not taken
    pc_src = 3'd1; cond = 1'b1; imm32 = 32'hFFFF_FFFE;
    cyc(); chk("br_taken", pc, 32'h0C);
    pc_src = 3'd0; cyc();
    pc_src = 3'd1; cond = 1'b0;
    cyc(); chk("br_not_taken", pc, 32'h14);

    // irq: synchroniser latency, vector, epc, return
    drive(3'd2, 32'h0, 26'h10); cyc(); chk("j_0x40", pc, 32'h40);
    pc_src = 3'd0; irq_in = 1'b1;
    cyc(); cyc();
    #1 chk("irq_early", 32'(irq_take), 32'h0);
    cyc();
    #1 chk("irq_after3", 32'(irq_take), 32'h1);
    cyc(); chk("irq_vec", pc, ILLOP_V); chk("irq_epc", epc, 32'h4C);
    irq_in = 1'b0;
    drive(3'd3, 32'h4C, '0); cyc();
    chk("eret_pc", pc, 32'h4C); chk("eret_kernel", 32'(kernel), 32'h0);

    // irq masked in kernel mode, taken after leaving it
    pc_src = 3'd4; cyc();
    pc_src = 3'd0; irq_in = 1'b1; cyc();
    irq_in = 1'b0; repeat (5) cyc();
    #1 chk("irq_masked", 32'(irq_take), 32'h0);
    drive(3'd3, 32'h100, '0); cyc();
    #1 chk("jr_user_pc", pc, 32'h100);
    chk("irq_unmasked", 32'(irq_take), 32'h1);
    pc_src = 3'd0; cyc();
    chk("irq2_vec", pc, ILLOP_V); chk("irq2_epc", epc, 32'h100);
    drive(3'd3, 32'h100, '0); cyc();

    // misaligned jr, then exception beating a pending irq
    drive(3'd3, 32'h202, '0);
    #1 chk("misalign_exc", 32'(exc_take), 32'h1);
    cyc(); chk("misalign_pc", pc, XADR_V); chk("misalign_epc", epc, 32'h100);
    drive(3'd3, 32'h200, '0); cyc();
    advance = 1'b0; pc_src = 3'd0; irq_in = 1'b1;
    repeat (4) cyc();
    irq_in = 1'b0;
    #1 chk("stall_pend_irq", 32'(irq_take), 32'h1);
    chk("stall_pc", pc, 32'h200);
    advance = 1'b1; illegal_op = 1'b1;
    #1 chk("exc_wins", 32'(exc_take), 32'h1);
    chk("irq_loses", 32'(irq_take), 32'h0);
    cyc(); chk("ill_pc", pc, XADR_V); chk("ill_epc", epc, 32'h200);
    illegal_op = 1'b0; drive(3'd3, 32'h204, '0); cyc();
    #1 chk("pend_kept", 32'(irq_take), 32'h1);
    pc_src = 3'd0; cyc(); chk("pend_taken", pc, ILLOP_V);

    // wrap: kernel bit is never reached by increment
    drive(3'd3, 32'h7FFF_FFFC, '0); cyc();
    pc_src = 3'd0; cyc(); chk("wrap_user", pc, 32'h0);
    drive(3'd3, 32'hFFFF_FFFC, '0); cyc();
    pc_src = 3'd0; cyc(); chk("wrap_kernel", pc, 32'h8000_0000);
    drive(3'd3, 32'h300, '0); cyc();

    // stall holds pc, async reset mid-stall
    held = pc;
    advance = 1'b0; drive(3'd2, 32'h0, 26'h3FF_FFFF);
    repeat (5) cyc();
    chk("stall_hold", pc, held);
    pulse_reset();
    advance = 1'b1;

    // redirect trace: 10 jumps, read newest first
    for (int i = 0; i < 10; i++) begin
      drive(3'd2, 32'h0, 26'(i + 1));
      cyc();
    end
    advance = 1'b0;
    for (int k = 0; k < TD; k++) begin
      trace_idx = 3'(k);
`ifdef PC_TRACE_EN
      exp_tr = 32'((10 - k) * 4);
`else
      exp_tr = 32'h0;
`endif
      #1 chk("trace_entry", trace_pc, exp_tr);
      cyc();
    end
    advance = 1'b1;

    // random run against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      advance = ($urandom % 5) != 0;
      r = int'($urandom % 16);
      if (r < 7)       pc_src = 3'd0;
      else if (r < 9)  pc_src = 3'd1;
      else if (r < 11) pc_src = 3'd2;
      else if (r < 13) pc_src = 3'd3;
      else if (r == 13) pc_src = 3'd4;
      else if (r == 14) pc_src = 3'd5;
      else             pc_src = 3'(6 + ($urandom % 2));
      cond = 1'($urandom);
      imm32 = $urandom;
      jt = 26'($urandom);
      reg_target = $urandom;
      if (($urandom % 5) != 0) reg_target[1:0] = 2'b00;
      illegal_op = ($urandom % 20) == 0;
      if (($urandom % 6) == 0) irq_in = ~irq_in;
      trace_idx = 3'($urandom);
      if (($urandom % 250) == 0) pulse_reset();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
